i2c_init_seq: RTL
=================

// Module: i2c_init_seq
// PURPOSE
//  Table-driven I2C command sequencer. Sits directly upstream of the I2C byte-transfer master.
//  On start_i it walks a synchronous command ROM and issues one register write or read per entry.
//  It applies inter-command delays, retries NACKed transfers, and reports read-back bytes and the final status.
//  Used for codec/sensor power-up init and periodic register polls.
// PARAMETERS
//  AW       6    ROM address width; table depth is 2**AW entries
//  RETRIES  3    extra attempts after a NACK before aborting (0 = no retry)
//  DLY_DIV  12   clk cycles per delay unit (12 MHz -> 1 us)
// PORTS
//  clk_i       in   1   clock
//  rst_ni      in   1   async reset, active low
//  srst_i      in   1   sync reset, active high; same effect as rst_ni
//  start_i     in   1   run table from index 0; ignored while busy_o
//  busy_o      out  1   sequence in progress
//  done_o      out  1   1-cycle pulse: sequence finished, err_o valid
//  err_o       out  1   last run aborted on NACK (held until next start)
//  err_idx_o   out  AW  index of the failing entry (held with err_o)
//  rd_val_o    out  1   1-cycle pulse: read byte available
//  rd_idx_o    out  AW  table index of the read
//  rd_data_o   out  8   read byte
//  tbl_addr_o  out  AW  ROM address (registered)
//  tbl_data_i  in   26  ROM word, valid 1 cycle after tbl_addr_o
//  m_val_o     out  1   request to master (valid)
//  m_daddr_o   out  7   device address
//  m_addr_o    out  8   register address
//  m_data_o    out  8   write data
//  m_wen_o     out  1   1 = write, 0 = read
//  m_rdy_i     in   1   master accepts request
//  s_val_i     in   1   master result valid
//  s_err_i     in   1   transfer NACKed
//  s_data_i    in   8   read data from master
//  s_rdy_o     out  1   sequencer accepts result
// BEHAVIOUR
//  - ROM word: [25:24] op (0 XFER, 1 DELAY, 2 END, 3 rsvd = END), [23] wen, [22:16] daddr, [15:8] addr, [7:0] data.
//    For DELAY, {addr,data} is a 16-bit count in DLY_DIV units.
//  - Reset: all outputs 0; state IDLE; idx 0; retry count 0.
//  - FSM:
//    IDLE   -start_i-> FETCH (idx=0, err_o cleared)
//    FETCH  1 cycle, tbl_addr_o=idx -> DECODE
//    DECODE latch word, branch on op: XFER -> ISSUE; DELAY -> WAIT_DLY, or NEXT if count=0; END -> FIN
//    ISSUE  m_val_o=1, payload stable; handshake m_val_o&m_rdy_i -> RESP
//    RESP   s_rdy_o=1; on s_val_i:
//           ok & read -> pulse rd_val_o (idx, s_data_i), then NEXT
//           ok & write -> NEXT
//           err & tries<RETRIES -> tries++, ISSUE
//           err otherwise -> err_o=1, err_idx_o=idx, FIN
//    WAIT_DLY count*DLY_DIV cycles -> NEXT
//    NEXT   tries=0; if idx==2**AW-1 -> FIN (implicit END), else idx++ -> FETCH
//    FIN    pulse done_o -> IDLE
//  - busy_o=1 in every state except IDLE.
//  - m_val_o never drops before m_rdy_i.
//  - Results are never accepted outside RESP; s_rdy_o=0 there.
//  - Delay counters: 16-bit unit count plus a clog2(DLY_DIV) prescaler; no wrap.
//  - Latency: start_i to first m_val_o = 3 cycles.
//  - start_i coincident with done_o is ignored. srst_i mid-transfer aborts immediately;
//    the master is expected to share srst_i.
// STRUCTURE
//  - Shared package i2c_pkg: op enum (OP_XFER/OP_DELAY/OP_END), i2c_cmd_t packed struct
//    matching the ROM word, and the state enum.
//  - Single module; no sub-modules. The ROM is external so tables can be swapped per board.
// TESTING
//  - Writes: ROM {XFER w 0x1A/0x02/0x55, END}; master model ACKs.
//    -> one request 0x1A,0x02,0x55,wen=1; done_o after response; err_o=0.
//  - Read: ROM {XFER r 0x48/0x00, END}; model returns 0xA7.
//    -> rd_val_o pulse, rd_idx_o=0, rd_data_o=0xA7.
//  - Retry: RETRIES=3, model NACKs 2x then ACKs.
//    -> 3 requests for the same entry, err_o=0.
//    Model NACKs 4x -> err_o=1, err_idx_o=0, done_o.
//  - Delay: DLY_DIV=12, entry DELAY count=5.
//    -> next m_val_o no earlier than 60 cycles after DECODE.
//    count=0 -> no wait.
//  - Stalls: m_rdy_i held low 20 cycles -> m_val_o and payload stable.
//    s_val_i delayed -> no early done_o.
//  - srst_i during RESP -> all outputs 0 next cycle, IDLE.
//    Table without END -> implicit finish after entry 2**AW-1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C init sequencer: ROM word layout, op codes and FSM states.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_XFER  = 2'd0,
    OP_DELAY = 2'd1,
    OP_END   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic       wen;
    logic [6:0] daddr;
    logic [7:0] addr;
    logic [7:0] data;
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_RESP,
    S_WAIT_DLY,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/i2c_init_seq.sv
// Table-driven I2C command sequencer: walks an external command ROM and drives a byte-transfer master,
// with inter-command delays, NACK retries, read-back reporting and a final status.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int AW      = 6,
  parameter int RETRIES = 3,
  parameter int DLY_DIV = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          srst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] err_idx_o,
  output logic          rd_val_o,
  output logic [AW-1:0] rd_idx_o,
  output logic [7:0]    rd_data_o,
  output logic [AW-1:0] tbl_addr_o,
  input  logic [25:0]   tbl_data_i,
  output logic          m_val_o,
  output logic [6:0]    m_daddr_o,
  output logic [7:0]    m_addr_o,
  output logic [7:0]    m_data_o,
  output logic          m_wen_o,
  input  logic          m_rdy_i,
  input  logic          s_val_i,
  input  logic          s_err_i,
  input  logic [7:0]    s_data_i,
  output logic          s_rdy_o
);

  localparam int PW = (DLY_DIV > 1) ? $clog2(DLY_DIV) : 1;
  localparam int TW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [AW-1:0] IDX_LAST = '1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DLY_DIV - 1);
  localparam logic [TW-1:0] TRY_MAX  = TW'(RETRIES);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [15:0]   dly_q, dly_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wen_q, wen_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic          rd_val_q, rd_val_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    rd_data_q, rd_data_d;
  i2c_cmd_t      word;

  assign word = i2c_cmd_t'(tbl_data_i);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    dly_d     = dly_q;
    pre_d     = pre_q;
    wen_d     = wen_q;
    daddr_d   = daddr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    rd_val_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_FETCH;
        idx_d     = '0;
        tries_d   = '0;
        err_d     = 1'b0;
        err_idx_d = '0;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        wen_d   = word.wen;
        daddr_d = word.daddr;
        addr_d  = word.addr;
        data_d  = word.data;
        case (word.op)
          OP_XFER: state_d = S_ISSUE;
          OP_DELAY: begin
            dly_d   = {word.addr, word.data};
            pre_d   = '0;
            state_d = ({word.addr, word.data} == 16'd0) ? S_NEXT : S_WAIT_DLY;
          end
          default: state_d = S_FIN;
        endcase
      end
      S_ISSUE: if (m_rdy_i) state_d = S_RESP;
      S_RESP: if (s_val_i) begin
        if (!s_err_i) begin
          if (!wen_q) begin
            rd_val_d  = 1'b1;
            rd_idx_d  = idx_q;
            rd_data_d = s_data_i;
          end
          state_d = S_NEXT;
        end else if (tries_q < TRY_MAX) begin
          tries_d = tries_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_FIN;
        end
      end
      // prescaler wraps every DLY_DIV cycles; the unit count ends the wait at its last unit
      S_WAIT_DLY: begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (dly_q == 16'd1) state_d = S_NEXT;
          else                dly_d   = dly_q - 16'd1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_NEXT: begin
        tries_d = '0;
        if (idx_q == IDX_LAST) state_d = S_FIN;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // sync reset has the same effect as the async one, one cycle later
    if (srst_i) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      tries_d   = '0;
      dly_d     = '0;
      pre_d     = '0;
      wen_d     = 1'b0;
      daddr_d   = '0;
      addr_d    = '0;
      data_d    = '0;
      err_d     = 1'b0;
      err_idx_d = '0;
      rd_val_d  = 1'b0;
      rd_idx_d  = '0;
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tries_q   <= '0;
      dly_q     <= '0;
      pre_q     <= '0;
      wen_q     <= 1'b0;
      daddr_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      rd_val_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tries_q   <= tries_d;
      dly_q     <= dly_d;
      pre_q     <= pre_d;
      wen_q     <= wen_d;
      daddr_q   <= daddr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      rd_val_q  <= rd_val_d;
      rd_idx_q  <= rd_idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_FIN);
  assign m_val_o    = (state_q == S_ISSUE);
  assign s_rdy_o    = (state_q == S_RESP);
  assign tbl_addr_o = idx_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;
  assign rd_val_o   = rd_val_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_data_o  = rd_data_q;
  assign m_wen_o    = wen_q;
  assign m_daddr_o  = daddr_q;
  assign m_addr_o   = addr_q;
  assign m_data_o   = data_q;

endmodule
